// File: rtl/swg_read_sequencer_pkg.sv
// Shared types and helpers for the sliding-window read sequencer:
// the FSM state type, the loop-level count and loop-bound helpers.
package swg;

  localparam int CNT_W = 16;
  localparam int N_LVL = 5;  // levels inner to outer: s, kw, kh, ow, oh

  typedef enum logic [2:0] {
    STATE_START     = 3'd0,
    STATE_LOOP_SIMD = 3'd1,
    STATE_LOOP_KW   = 3'd2,
    STATE_LOOP_KH   = 3'd3,
    STATE_LOOP_W    = 3'd4,
    STATE_LOOP_H    = 3'd5
  } state_e;

  // Outermost level that advances on the next handshake; a level whose
  // counter already sits at its maximum (including bound-1 levels) is skipped.
  function automatic state_e loop_state(input logic [N_LVL-1:0] at_max);
    if (&at_max)    return STATE_LOOP_H;
    if (!at_max[0]) return STATE_LOOP_SIMD;
    if (!at_max[1]) return STATE_LOOP_KW;
    if (!at_max[2]) return STATE_LOOP_KH;
    if (!at_max[3]) return STATE_LOOP_W;
    return STATE_LOOP_H;
  endfunction

  function automatic logic [CNT_W-1:0] bound_max(input int bound);
    return CNT_W'(bound - 1);
  endfunction

endpackage

// File: rtl/swg_loop_counter.sv
// One wrapping loop counter: clears on a new frame, steps on enable and
// flags when the current and the next value sit at the loop maximum.
module swg_loop_counter
  import swg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] max,
  output logic             wrap,
  output logic             wrap_next
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign wrap      = (count_q == max);
  assign wrap_next = (count_d == max);

endmodule

// File: rtl/swg_read_sequencer.sv
// Sliding-window buffer read-address sequencer: walks oh/ow/kh/kw/s and
// emits one wrapped buffer address per valid/ready handshake.
module swg_read_sequencer
  import swg::*;
#(
  parameter int IFM_W     = 8,
  parameter int OFM_H     = 6,
  parameter int OFM_W     = 6,
  parameter int K_H       = 3,
  parameter int K_W       = 3,
  parameter int SIMD_FOLD = 1,
  parameter int STRIDE_H  = 1,
  parameter int STRIDE_W  = 1,
  parameter int BUF_DEPTH = 64,
  localparam int ADDR_W   = $clog2(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [2:0]        state
);

  if (OFM_H < 1 || OFM_W < 1 || K_H < 1 || K_W < 1 || SIMD_FOLD < 1 ||
      STRIDE_H < 1 || STRIDE_W < 1 || IFM_W < 1 || BUF_DEPTH < 2 ||
      (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_param_err
    $error("swg_read_sequencer: illegal parameter set");
  end

  localparam int BOUND [N_LVL] = '{SIMD_FOLD, K_W, K_H, OFM_W, OFM_H};
  // Address contribution of one step at each level, reduced mod BUF_DEPTH.
  localparam logic [ADDR_W-1:0] STEP [N_LVL] = '{
    ADDR_W'(1),
    ADDR_W'(SIMD_FOLD),
    ADDR_W'(IFM_W * SIMD_FOLD),
    ADDR_W'(STRIDE_W * SIMD_FOLD),
    ADDR_W'(STRIDE_H * IFM_W * SIMD_FOLD)
  };

  // Handshake: a word moves when out_valid & out_ready. While stalled every
  // register holds, so out_valid/out_addr/out_last stay stable.
  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  off_q [N_LVL];
  logic [ADDR_W-1:0]  off_d [N_LVL];
  logic [N_LVL-1:0]   en, wrap, wrap_next;
  logic               hs, start_acc, final_hs;
  logic [ADDR_W-1:0]  addr_sum;

  for (genvar i = 0; i < N_LVL; i++) begin : g_lvl
    swg_loop_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_acc),
      .en        (en[i]),
      .max       (bound_max(BOUND[i])),
      .wrap      (wrap[i]),
      .wrap_next (wrap_next[i])
    );
  end

  always_comb begin
    hs        = (state_q != STATE_START) & out_ready;
    start_acc = start & (state_q == STATE_START);
    final_hs  = hs & (&wrap);
    en        = '0;
    en[0]     = hs;
    for (int i = 1; i < N_LVL; i++) en[i] = en[i-1] & wrap[i-1];

    state_d = state_q;
    if (final_hs) state_d = STATE_START;
    else if (start_acc || state_q != STATE_START) state_d = loop_state(wrap_next);
    done_d = final_hs;

    for (int i = 0; i < N_LVL; i++) begin
      off_d[i] = off_q[i];
      if (start_acc) off_d[i] = '0;
      else if (en[i]) off_d[i] = wrap[i] ? '0 : off_q[i] + STEP[i];
    end

    addr_sum = '0;
    for (int i = 0; i < N_LVL; i++) addr_sum = addr_sum + off_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_START;
      done_q  <= 1'b0;
      for (int i = 0; i < N_LVL; i++) off_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      for (int i = 0; i < N_LVL; i++) off_q[i] <= off_d[i];
    end
  end

  assign busy      = (state_q != STATE_START);
  assign out_valid = busy;
  assign out_last  = busy & (&wrap[2:0]);
  assign out_addr  = addr_sum;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_swg_read_sequencer.sv
// Bench for swg_read_sequencer: three configurations (basic, SIMD fold 2,
// small wrapping buffer) checked against a nested-loop reference model.
module tb_swg_read_sequencer;
  import swg::*;

  localparam int IFM = 4, OH_N = 2, OW_N = 2, KH_N = 2, KW_N = 2;
  int cfg_sf    [3] = '{1, 2, 1};
  int cfg_depth [3] = '{16, 32, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] start_v = '0, ready_v = '0;
  logic [2:0] valid_v, busy_v, done_v, last_v;
  logic [3:0] addr_a;
  logic [4:0] addr_b;
  logic [2:0] addr_c;
  logic [2:0] state_a, state_b, state_c;
  logic [4:0] addr_x  [3];
  logic [2:0] state_x [3];

  assign addr_x[0] = {1'b0, addr_a};
  assign addr_x[1] = addr_b;
  assign addr_x[2] = {2'b00, addr_c};
  assign state_x[0] = state_a;
  assign state_x[1] = state_b;
  assign state_x[2] = state_c;

  swg_read_sequencer #(.IFM_W(4), .OFM_H(2), .OFM_W(2), .K_H(2), .K_W(2), .SIMD_FOLD(1),
    .STRIDE_H(1), .STRIDE_W(1), .BUF_DEPTH(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .out_addr(addr_a), .out_valid(valid_v[0]), .out_ready(ready_v[0]),
    .out_last(last_v[0]), .state(state_a));

  swg_read_sequencer #(.IFM_W(4), .OFM_H(2), .OFM_W(2), .K_H(2), .K_W(2), .SIMD_FOLD(2),
    .STRIDE_H(1), .STRIDE_W(1), .BUF_DEPTH(32)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .out_addr(addr_b), .out_valid(valid_v[1]), .out_ready(ready_v[1]),
    .out_last(last_v[1]), .state(state_b));

  swg_read_sequencer #(.IFM_W(4), .OFM_H(2), .OFM_W(2), .K_H(2), .K_W(2), .SIMD_FOLD(1),
    .STRIDE_H(1), .STRIDE_W(1), .BUF_DEPTH(8)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .out_addr(addr_c), .out_valid(valid_v[2]), .out_ready(ready_v[2]),
    .out_last(last_v[2]), .state(state_c));

  int n_checks = 0;
  int n_errors = 0;
  // Expected word: {state[2:0], last, addr[4:0]}
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the frame's words in order, from the address formula.
  task automatic build_exp(input int id);
    int sf, depth, a;
    logic lst;
    state_e st;
    sf    = cfg_sf[id];
    depth = cfg_depth[id];
    exp_q.delete();
    for (int oh = 0; oh < OH_N; oh++)
      for (int ow = 0; ow < OW_N; ow++)
        for (int kh = 0; kh < KH_N; kh++)
          for (int kw = 0; kw < KW_N; kw++)
            for (int s = 0; s < sf; s++) begin
              a   = (((oh + kh) * IFM + ow + kw) * sf + s) % depth;
              lst = (s == sf - 1) && (kw == KW_N - 1) && (kh == KH_N - 1);
              if (s < sf - 1)          st = STATE_LOOP_SIMD;
              else if (kw < KW_N - 1)  st = STATE_LOOP_KW;
              else if (kh < KH_N - 1)  st = STATE_LOOP_KH;
              else if (ow < OW_N - 1)  st = STATE_LOOP_W;
              else                     st = STATE_LOOP_H;
              exp_q.push_back({st, lst, 5'(a)});
            end
  endtask

  task automatic check_idle(input int id, input string tag);
    check({tag, "_valid"}, 32'(valid_v[id]), 0);
    check({tag, "_busy"},  32'(busy_v[id]),  0);
    check({tag, "_done"},  32'(done_v[id]),  0);
    check({tag, "_last"},  32'(last_v[id]),  0);
    check({tag, "_addr"},  32'(addr_x[id]),  0);
    check({tag, "_state"}, 32'(state_x[id]), 32'(STATE_START));
  endtask

  // Called at a falling edge; start is sampled on the following rising edge.
  task automatic start_frame(input int id);
    start_v[id] = 1'b1;
    ready_v[id] = 1'b0;
    @(negedge clk);
    start_v[id] = 1'b0;
    check("first_valid", 32'(valid_v[id]), 1);
    check("first_busy",  32'(busy_v[id]),  1);
    check("first_addr",  32'(addr_x[id]),  0);
    check("first_done",  32'(done_v[id]),  0);
  endtask

  task automatic drain(input int id, input int pct, input int limit, input bit poke);
    logic [8:0] e;
    logic       stalled, prev_last, r;
    logic [4:0] prev_addr;
    int         hs_n, cyc;
    build_exp(id);
    stalled = 1'b0; prev_last = 1'b0; prev_addr = '0; hs_n = 0; cyc = 0;
    while (exp_q.size() > 0 && hs_n < limit && cyc < 2000) begin
      check("valid", 32'(valid_v[id]), 1);
      if (stalled) begin
        check("hold_addr", 32'(addr_x[id]), 32'(prev_addr));
        check("hold_last", 32'(last_v[id]), 32'(prev_last));
      end
      r = ($urandom_range(0, 99) < pct);
      ready_v[id] = r;
      if (poke) start_v[id] = 1'($urandom_range(0, 1));
      if (r) begin
        e = exp_q.pop_front();
        check("addr",  32'(addr_x[id]),  32'(e[4:0]));
        check("last",  32'(last_v[id]),  32'(e[5]));
        check("state", 32'(state_x[id]), 32'(e[8:6]));
        hs_n++;
      end
      stalled   = !r;
      prev_addr = addr_x[id];
      prev_last = last_v[id];
      @(negedge clk);
      cyc++;
    end
    ready_v[id] = 1'b0;
    start_v[id] = 1'b0;
    if (hs_n < limit) begin
      check("frame_left", 32'(exp_q.size()), 0);
      check("done_pulse", 32'(done_v[id]),  1);
      check("end_valid",  32'(valid_v[id]), 0);
      check("end_busy",   32'(busy_v[id]),  0);
      check("end_state",  32'(state_x[id]), 32'(STATE_START));
    end
  endtask

  task automatic after_done(input int id);
    @(negedge clk);
    check("done_drop",  32'(done_v[id]),  0);
    check("idle_valid", 32'(valid_v[id]), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++) check_idle(id, "in_reset");
    rst = 1'b0;
    @(negedge clk);
    for (int id = 0; id < 3; id++) check_idle(id, "post_reset");

    // Full-rate frames on every configuration (basic, SIMD fold, buffer wrap).
    for (int id = 0; id < 3; id++) begin
      start_frame(id);
      drain(id, 100, 1000, 1'b0);
      after_done(id);
    end

    // Backpressure with start poked while busy, then start coincident with done.
    start_frame(0);
    drain(0, 30, 1000, 1'b1);
    start_frame(0);
    drain(0, 100, 1000, 1'b0);
    after_done(0);

    // Reset mid-frame after five handshakes.
    start_frame(0);
    drain(0, 100, 5, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(valid_v[0]), 0);
    @(negedge clk);
    check_idle(0, "mid_reset");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abandoned_valid", 32'(valid_v[0]), 0);
    end
    start_frame(0);
    drain(0, 30, 1000, 1'b0);
    after_done(0);

    // Random backpressure on the other two configurations.
    for (int id = 1; id < 3; id++) begin
      start_frame(id);
      drain(id, 30, 1000, 1'b1);
      after_done(id);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/swg_read_sequencer.md
SWG_READ_SEQUENCER -- requirements
Module: swg_read_sequencer

Interface
REQ-001 Parameters SHALL be as follows; parameters SHALL be checked at elaboration (OFM_*, K_*, SIMD_FOLD, STRIDE_* >= 1).
  - IFM_W, default 8: input frame width in pixels.
  - OFM_H / OFM_W, default 6 / 6: output window rows / columns.
  - K_H / K_W, default 3 / 3: kernel height / width.
  - SIMD_FOLD, default 1: buffer words per pixel.
  - STRIDE_H / STRIDE_W, default 1 / 1: window strides.
  - BUF_DEPTH, default 64: buffer words; a power of two.
REQ-002 Ports SHALL be as follows; ADDR_W = $clog2(BUF_DEPTH).
  - clk, in, 1: the single clock, rising edge.
  - rst, in, 1: asynchronous, active-high reset.
  - start, in, 1: request one frame.
  - busy, out, 1: frame in progress.
  - done, out, 1: one-cycle pulse at frame end.
  - out_addr, out, ADDR_W: buffer read address.
  - out_valid, out, 1: out_addr is valid.
  - out_ready, in, 1: consumer accepts.
  - out_last, out, 1: last word of the current window.
  - state, out, 3: current swg::state_e.

Function
REQ-003 Loop nest, outer to inner: oh<OFM_H, ow<OFM_W, kh<K_H, kw<K_W, s<SIMD_FOLD.
REQ-004 out_addr SHALL be (((oh*STRIDE_H+kh)*IFM_W + ow*STRIDE_W+kw)*SIMD_FOLD + s) mod BUF_DEPTH.
REQ-005 Addresses SHALL be built from incremental adds and offsets held in registers; no run-time multipliers.
REQ-006 A handshake SHALL be out_valid & out_ready; counters and out_addr SHALL change only on a handshake.
REQ-007 out_valid, out_addr and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-008 start SHALL be accepted only in STATE_START; start while busy SHALL be ignored.
REQ-009 On the cycle after start is accepted: out_valid=1, busy=1 and out_addr=0 (all counters zero).
REQ-010 While busy, state SHALL name the outermost loop that advances on the next handshake.
  - STATE_LOOP_SIMD: only s increments.
  - STATE_LOOP_KW: s wraps, kw increments.
  - STATE_LOOP_KH: kw wraps, kh increments.
  - STATE_LOOP_W: kh wraps, ow increments.
  - STATE_LOOP_H: ow wraps, oh increments.
REQ-011 In STATE_LOOP_H, a handshake on the final element (all counters at max) SHALL return state to STATE_START.
  - That handshake clears out_valid and busy on the next cycle.
  - done SHALL be 1 for exactly that next cycle.
REQ-012 out_last SHALL be 1 when s, kw and kh are all at max.
REQ-013 Where a loop bound is 1, that level SHALL be skipped in state encoding (e.g. SIMD_FOLD=1 never shows STATE_LOOP_SIMD).
REQ-014 Address arithmetic SHALL wrap modulo BUF_DEPTH with no gap or stall at the wrap point.
REQ-015 start asserted in the same cycle as done SHALL be accepted; the next frame's valid follows one cycle later.
REQ-016 Throughput SHALL be one address per cycle while out_ready=1.

Reset
REQ-017 While rst=1, and after release:
  - out_valid=0, busy=0, done=0, out_last=0, out_addr=0.
  - All counters and offset registers at 0.
  - state=STATE_START.
REQ-018 Reset mid-frame SHALL abandon the frame; no further addresses are issued until a new start.

Structure
REQ-019 The state type SHALL be swg::state_e from the shared swg package; no local redefinition.
REQ-020 Any added loop-bound helper functions or constants SHALL go in the swg package.
REQ-021 One sub-module, swg_loop_counter, SHALL hold one wrapping counter (enable, max, wrap flag), instanced five times.

Verification
REQ-022 Basic addressing.
  - Config: IFM_W=4, OFM 2x2, K 2x2, SIMD_FOLD=1, stride 1, BUF_DEPTH=16, out_ready=1.
  - Expected addresses: 0,1,4,5 | 1,2,5,6 | 4,5,8,9 | 5,6,9,10.
  - out_last on every 4th word; done one cycle after the 16th handshake.
REQ-023 SIMD folding: same config with SIMD_FOLD=2 and BUF_DEPTH=32; first window SHALL be 0,1,2,3,8,9,10,11, with state sequence SIMD,KW,SIMD,KH,...
REQ-024 Buffer wrap: REQ-022 config with BUF_DEPTH=8; window 3 SHALL be 4,5,0,1 with no bubble.
REQ-025 Backpressure: random out_ready at 30% duty; the address stream SHALL equal the REQ-022 sequence and out_addr SHALL hold while stalled.
REQ-026 Reset and start handling:
  - rst mid-frame after 5 handshakes: out_valid=0 next cycle.
  - A new start afterwards restarts at address 0.
  - start while busy: no effect.
  - start coincident with done: second frame begins one cycle later.
